// File: rtl/cpu_pkg.sv
// Shared constants, state encoding and width helpers
// for the parametrised multi-cycle core.
package cpu_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_ADD  = 3'd0;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'd1;
  localparam logic [OPC_W-1:0] OP_AND  = 3'd2;
  localparam logic [OPC_W-1:0] OP_OR   = 3'd3;
  localparam logic [OPC_W-1:0] OP_XOR  = 3'd4;
  localparam logic [OPC_W-1:0] OP_SHL  = 3'd5;
  localparam logic [OPC_W-1:0] OP_SHR  = 3'd6;
  localparam logic [OPC_W-1:0] OP_HALT = 3'd7;

  localparam logic MODE_REG = 1'b0;
  localparam logic MODE_IMM = 1'b1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALTED
  } state_e;

  function automatic int reg_aw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int instr_w(input int dw, input int aw);
    int r;
    r = OPC_W + 2 * aw;
    return 1 + aw + ((dw > r) ? dw : r);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: value and carry/borrow
// for every register-mode opcode.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
)(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OPC_W-1:0]  i_opc,
  output logic [DATA_W-1:0] o_value,
  output logic              o_carry
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // Top bit of the widened difference is the borrow (A < B)
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_value = '0;
    o_carry = 1'b0;
    unique case (i_opc)
      OP_ADD: {o_carry, o_value} = w_sum;
      OP_SUB: {o_carry, o_value} = w_diff;
      OP_AND: o_value = i_a & i_b;
      OP_OR:  o_value = i_a | i_b;
      OP_XOR: o_value = i_a ^ i_b;
      OP_SHL: begin
        o_value = {i_a[DATA_W-2:0], 1'b0};
        o_carry = i_a[DATA_W-1];
      end
      OP_SHR: begin
        o_value = {1'b0, i_a[DATA_W-1:1]};
        o_carry = i_a[0];
      end
      default: begin
        o_value = '0;
        o_carry = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_core_param.sv
// Multi-cycle core: handshake accept, register file,
// decode and a FETCH/DECODE/EXECUTE/WRITEBACK/HALTED FSM.
module cpu_core_param
  import cpu_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int NREGS   = 8,
  localparam int REG_AW  = reg_aw(NREGS),
  localparam int INSTR_W = instr_w(DATA_W, REG_AW)
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  result,
  output logic               result_valid,
  output logic               flag_z,
  output logic               flag_c,
  output logic               halted
);

  state_e r_state;
  state_e w_state_nxt;

  logic [INSTR_W-1:0] r_instr;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_result;
  logic               r_valid;
  logic               r_z;
  logic               r_c;
  logic [DATA_W-1:0]  r_regs [NREGS];

  logic              w_mode;
  logic [OPC_W-1:0]  w_opc;
  logic [REG_AW-1:0] w_dst_imm;
  logic [REG_AW-1:0] w_dst_reg;
  logic [REG_AW-1:0] w_dst;
  logic [REG_AW-1:0] w_src_a;
  logic [REG_AW-1:0] w_src_b;
  logic [DATA_W-1:0] w_imm;
  logic              w_halt;
  logic [DATA_W-1:0] w_alu_val;
  logic              w_alu_c;
  logic [DATA_W-1:0] w_wb_val;
  logic              w_wb_c;

  assign w_mode    = r_instr[INSTR_W-1];
  assign w_opc     = r_instr[INSTR_W-2 -: OPC_W];
  assign w_dst_imm = r_instr[INSTR_W-2 -: REG_AW];
  assign w_dst_reg = r_instr[INSTR_W-2-OPC_W -: REG_AW];
  assign w_src_a   = r_instr[INSTR_W-2-OPC_W-REG_AW -: REG_AW];
  assign w_src_b   = r_instr[INSTR_W-2-OPC_W-2*REG_AW -: REG_AW];
  assign w_imm     = r_instr[DATA_W-1:0];
  assign w_dst     = (w_mode == MODE_IMM) ? w_dst_imm : w_dst_reg;
  assign w_halt    = (w_mode == MODE_REG) && (w_opc == OP_HALT);

  cpu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_opc   (w_opc),
    .o_value (w_alu_val),
    .o_carry (w_alu_c)
  );

  assign w_wb_val = (w_mode == MODE_IMM) ? w_imm : w_alu_val;
  assign w_wb_c   = (w_mode == MODE_IMM) ? 1'b0 : w_alu_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_FETCH:     if (instr_valid) w_state_nxt = S_DECODE;
      S_DECODE:    w_state_nxt = S_EXECUTE;
      S_EXECUTE:   w_state_nxt = w_halt ? S_HALTED : S_WRITEBACK;
      S_WRITEBACK: w_state_nxt = S_FETCH;
      S_HALTED:    w_state_nxt = S_HALTED;
      default:     w_state_nxt = S_FETCH;
    endcase
  end

  // Operands latch in DECODE, so a source equal to dest sees the old value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_valid  <= 1'b0;
      r_z      <= 1'b0;
      r_c      <= 1'b0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_FETCH: begin
          if (instr_valid) r_instr <= instr;
        end
        S_DECODE: begin
          r_a <= r_regs[w_src_a];
          r_b <= r_regs[w_src_b];
        end
        S_EXECUTE: begin
          if (!w_halt) begin
            r_result <= w_wb_val;
            r_c      <= w_wb_c;
            r_z      <= (w_wb_val == '0);
            r_valid  <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          r_regs[w_dst] <= r_result;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready  = (r_state == S_FETCH);
  assign halted       = (r_state == S_HALTED);
  assign result       = r_result;
  assign result_valid = r_valid;
  assign flag_z       = r_z;
  assign flag_c       = r_c;

endmodule

// File: tb/tb_cpu_core_param.sv
// Directed bench for cpu_core_param: default 8/8 build
// plus a 16-bit, 16-register build.
module tb_cpu_core_param;

  logic        clk = 1'b1;
  logic        reset = 1'b0;

  logic [12:0] instr8 = '0;
  logic        valid8 = 1'b0;
  logic        rdy8;
  logic [7:0]  res8;
  logic        rv8;
  logic        z8;
  logic        c8;
  logic        hlt8;

  logic [20:0] instr16 = '0;
  logic        valid16 = 1'b0;
  logic        rdy16;
  logic [15:0] res16;
  logic        rv16;
  logic        z16;
  logic        c16;
  logic        hlt16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_core_param #(.DATA_W(8), .NREGS(8)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr8),
    .instr_valid  (valid8),
    .instr_ready  (rdy8),
    .result       (res8),
    .result_valid (rv8),
    .flag_z       (z8),
    .flag_c       (c8),
    .halted       (hlt8)
  );

  cpu_core_param #(.DATA_W(16), .NREGS(16)) u_dut16 (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr16),
    .instr_valid  (valid16),
    .instr_ready  (rdy16),
    .result       (res16),
    .result_valid (rv16),
    .flag_z       (z16),
    .flag_c       (c16),
    .halted       (hlt16)
  );

  typedef struct packed {
    logic [12:0] ins;
    logic [7:0]  res;
    logic        c;
    logic        z;
  } vec_t;

  vec_t vecs [15];

  function automatic logic [12:0] imm8(input int d, input logic [7:0] v);
    logic [2:0] dd;
    dd = 3'(d);
    return {1'b1, dd, 1'b0, v};
  endfunction

  function automatic logic [12:0] reg8(input int op, input int d,
                                       input int a, input int b);
    logic [2:0] o3, d3, a3, b3;
    o3 = 3'(op); d3 = 3'(d); a3 = 3'(a); b3 = 3'(b);
    return {1'b0, o3, d3, a3, b3};
  endfunction

  function automatic logic [20:0] imm16(input int d, input logic [15:0] v);
    logic [3:0] dd;
    dd = 4'(d);
    return {1'b1, dd, v};
  endfunction

  function automatic logic [20:0] reg16(input int op, input int d,
                                        input int a, input int b);
    logic [2:0] o3;
    logic [3:0] d4, a4, b4;
    o3 = 3'(op); d4 = 4'(d); a4 = 4'(a); b4 = 4'(b);
    return {1'b0, o3, d4, a4, b4, 5'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic exec8(input logic [12:0] ins, input logic [7:0] er,
                       input logic ec, input logic ez, input string nm);
    int n;
    n = 0;
    while (rdy8 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready"}, 32'(rdy8), 1);
    instr8 = ins;
    valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid8 = 1'b0;
    instr8 = ~ins;
    chk({nm, " rv_e0"}, 32'(rv8), 0);
    @(negedge clk);
    chk({nm, " rv_e1"}, 32'(rv8), 0);
    @(negedge clk);
    chk({nm, " rv_e2"}, 32'(rv8), 1);
    chk({nm, " result"}, 32'(res8), 32'(er));
    chk({nm, " carry"}, 32'(c8), 32'(ec));
    chk({nm, " zero"}, 32'(z8), 32'(ez));
    @(negedge clk);
    chk({nm, " rv_e3"}, 32'(rv8), 0);
    chk({nm, " hold"}, 32'(res8), 32'(er));
  endtask

  task automatic exec16(input logic [20:0] ins, input logic [15:0] er,
                        input logic ec, input logic ez, input string nm);
    int n;
    n = 0;
    while (rdy16 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " ready"}, 32'(rdy16), 1);
    instr16 = ins;
    valid16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid16 = 1'b0;
    @(negedge clk);
    chk({nm, " rv_e1"}, 32'(rv16), 0);
    @(negedge clk);
    chk({nm, " rv_e2"}, 32'(rv16), 1);
    chk({nm, " result"}, 32'(res16), 32'(er));
    chk({nm, " carry"}, 32'(c16), 32'(ec));
    chk({nm, " zero"}, 32'(z16), 32'(ez));
    @(negedge clk);
    chk({nm, " rv_e3"}, 32'(rv16), 0);
  endtask

  initial begin
    logic [12:0] hs [3];
    logic [12:0] halt_w;
    int k;
    int nrdy;
    int nrv;
    int viol;

    vecs[0]  = '{imm8(3, 8'h04),    8'h04, 1'b0, 1'b0};
    vecs[1]  = '{imm8(2, 8'h03),    8'h03, 1'b0, 1'b0};
    vecs[2]  = '{reg8(0, 1, 3, 2),  8'h07, 1'b0, 1'b0};
    vecs[3]  = '{imm8(0, 8'hFF),    8'hFF, 1'b0, 1'b0};
    vecs[4]  = '{imm8(1, 8'h01),    8'h01, 1'b0, 1'b0};
    vecs[5]  = '{reg8(0, 2, 0, 1),  8'h00, 1'b1, 1'b1};
    vecs[6]  = '{reg8(1, 3, 1, 0),  8'h02, 1'b1, 1'b0};
    vecs[7]  = '{imm8(4, 8'h81),    8'h81, 1'b0, 1'b0};
    vecs[8]  = '{reg8(5, 5, 4, 4),  8'h02, 1'b1, 1'b0};
    vecs[9]  = '{reg8(6, 5, 4, 4),  8'h40, 1'b1, 1'b0};
    vecs[10] = '{reg8(4, 4, 4, 4),  8'h00, 1'b0, 1'b1};
    vecs[11] = '{reg8(3, 6, 0, 1),  8'hFF, 1'b0, 1'b0};
    vecs[12] = '{reg8(2, 7, 0, 3),  8'h02, 1'b0, 1'b0};
    vecs[13] = '{reg8(1, 7, 3, 1),  8'h01, 1'b0, 1'b0};
    vecs[14] = '{reg8(0, 3, 3, 1),  8'h03, 1'b0, 1'b0};

    #15;
    reset = 1'b1;
    @(negedge clk);
    chk("rst ready", 32'(rdy8), 1);
    chk("rst result", 32'(res8), 0);
    chk("rst rv", 32'(rv8), 0);
    chk("rst flags", 32'({z8, c8}), 0);
    chk("rst halted", 32'(hlt8), 0);
    chk("rst16 ready", 32'(rdy16), 1);
    chk("rst16 result", 32'(res16), 0);

    for (int i = 0; i < 15; i++)
      exec8(vecs[i].ins, vecs[i].res, vecs[i].c, vecs[i].z,
            $sformatf("vec%0d", i));

    // valid held high; stale instr is a HALT word that must be ignored
    halt_w = reg8(7, 0, 0, 0);
    hs[0] = imm8(5, 8'h11);
    hs[1] = imm8(6, 8'h22);
    hs[2] = reg8(0, 7, 5, 6);
    k = 0; nrdy = 0; nrv = 0;
    valid8 = 1'b1;
    for (int cyc = 0; cyc < 13; cyc++) begin
      chk($sformatf("hs ready c%0d", cyc), 32'(rdy8),
          32'((cyc % 4) == 0));
      if (rv8 === 1'b1) nrv++;
      if (rdy8 === 1'b1) begin
        nrdy++;
        if (k < 3) begin
          instr8 = hs[k];
          k++;
        end else begin
          valid8 = 1'b0;
        end
      end else begin
        instr8 = halt_w;
      end
      if (cyc < 12) @(negedge clk);
    end
    chk("hs ready count", 32'(nrdy), 4);
    chk("hs strobes", 32'(nrv), 3);
    chk("hs result", 32'(res8), 32'h33);
    chk("hs halted", 32'(hlt8), 0);

    instr8 = halt_w;
    valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr8 = imm8(0, 8'hAA);
    chk("halt e0", 32'(hlt8), 0);
    @(negedge clk);
    chk("halt e1", 32'(hlt8), 0);
    @(negedge clk);
    chk("halt e2", 32'(hlt8), 1);
    chk("halt ready", 32'(rdy8), 0);
    chk("halt rv", 32'(rv8), 0);
    viol = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (hlt8 !== 1'b1 || rdy8 !== 1'b0 || rv8 !== 1'b0) viol++;
    end
    chk("halt stays", 32'(viol), 0);
    chk("halt result", 32'(res8), 32'h33);
    valid8 = 1'b0;

    reset = 1'b0;
    #1;
    chk("rst2 halted", 32'(hlt8), 0);
    chk("rst2 result", 32'(res8), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst2 ready", 32'(rdy8), 1);

    instr8 = imm8(1, 8'h55);
    valid8 = 1'b1;
    @(posedge clk);
    #2;
    valid8 = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort ready", 32'(rdy8), 1);
    chk("abort rv", 32'(rv8), 0);
    chk("abort outs", 32'({res8, z8, c8, hlt8}), 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort rv idle", 32'(rv8), 0);
    exec8(reg8(0, 0, 0, 0), 8'h00, 1'b0, 1'b1, "clr r0");
    exec8(reg8(0, 2, 1, 3), 8'h00, 1'b0, 1'b1, "clr r1r3");

    exec16(imm16(15, 16'hFFFF), 16'hFFFF, 1'b0, 1'b0, "w16 r15");
    exec16(imm16(14, 16'h0001), 16'h0001, 1'b0, 1'b0, "w16 r14");
    exec16(reg16(0, 13, 15, 14), 16'h0000, 1'b1, 1'b1, "w16 add");
    exec16(reg16(1, 12, 14, 15), 16'h0002, 1'b1, 1'b0, "w16 sub");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
